// File: rtl/ifetch_ctrl_pkg.sv
// ifetch_ctrl_pkg: shared fetch-stage constants, FSM encoding and queue sizing
package ifetch_ctrl_pkg;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int INSTR_W = 32;
    localparam int FQ_DEPTH = 2;
    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/ifetch_ctrl_fetch_queue.sv
// fetch_queue: 2-entry shift FIFO of {pc,instr}; the head keeps its last value while empty
module fetch_queue
    import ifetch_ctrl_pkg::*;
#(
    parameter int DW = 32 + INSTR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] head_o,
    output logic [1:0]    count_o
);
    logic [DW-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0] count_q, count_d, kept;
    logic push, pop;
    // flush freezes the storage so the head holds; survivors shift forward and the new word lands behind them
    always_comb begin
        push    = push_i & ~flush_i;
        pop     = pop_i & ~flush_i;
        kept    = count_q - {1'b0, pop};
        e0_d    = (push && kept == 2'd0) ? data_i : ((pop && count_q == 2'd2) ? e1_q : e0_q);
        e1_d    = (push && kept != 2'd0) ? data_i : e1_q;
        count_d = flush_i ? 2'd0 : kept + {1'b0, push};
    end
    // storage and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= 2'd0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
        end
    end
    assign head_o  = e0_q;
    assign count_o = count_q;
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_i && !pop_i && !flush_i && count_q == 2'd2));
endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: owns the PC, issues imem reads under a queue credit and presents returned words to decode
module ifetch_ctrl
    import ifetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter int                DEPTH    = FQ_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  iaddr,
    input  logic [INSTR_W-1:0] idata,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic               misalign_err
);
    fetch_state_t state_q;
    logic [ADDR_W-1:0] pc_q, iaddr_q, inflight_pc_q, fetch_addr;
    logic [ADDR_W+INSTR_W-1:0] head;
    logic [1:0] count;
    logic [2:0] credit;
    logic inflight_q, pop, push, issue;
    // a redirect empties queue and in-flight slot, so it frees all credit; its return is squashed
    always_comb begin
        pop        = if_valid & if_ready;
        credit     = redirect_valid ? 3'd0 : 3'(count) + 3'(inflight_q) - 3'(pop);
        issue      = ~rst & (state_q == S_RUN) & ~halt & (credit < 3'(DEPTH));
        fetch_addr = redirect_valid ? {redirect_pc[ADDR_W-1:2], 2'b00} : pc_q;
        push       = inflight_q & ~redirect_valid;
    end
    // run/halt FSM, PC, in-flight tracking and sticky misalignment flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_RUN;
            pc_q          <= RESET_PC;
            iaddr_q       <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            misalign_err  <= 1'b0;
        end else begin
            state_q    <= halt ? S_HALT : S_RUN;
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= fetch_addr;
                iaddr_q       <= fetch_addr;
            end
            if (issue || redirect_valid)
                pc_q <= issue ? fetch_addr + ADDR_W'(4) : fetch_addr;
            if (redirect_valid && redirect_pc[1:0] != 2'b00)
                misalign_err <= 1'b1;
        end
    end
    fetch_queue #(.DW(ADDR_W + INSTR_W)) u_fq (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .pop_i  (pop),
        .flush_i(redirect_valid),
        .data_i ({inflight_pc_q, idata}),
        .head_o (head),
        .count_o(count)
    );
    assign iaddr           = issue ? fetch_addr : iaddr_q;
    assign if_valid        = count != 2'd0;
    assign {if_pc, if_instr} = head;
endmodule
